// File: rtl/mg995_parameters.sv
// Shared constants for the MG995 servo path: UART timing, PWM compare values,
// ASCII codes and the UART receive bit-FSM encoding.
package mg995_parameters;

  localparam int CLKS_PER_BIT = 5208;
  localparam int DATA_LENGTH  = 17;

  localparam int ANGLE_0_P   = 24999;
  localparam int ANGLE_90_P  = 74999;
  localparam int ANGLE_180_P = 124999;

  localparam logic [7:0] ASCII_0  = 8'h30;
  localparam logic [7:0] ASCII_9  = 8'h39;
  localparam logic [7:0] ASCII_CR = 8'h0D;
  localparam logic [7:0] ASCII_LF = 8'h0A;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP,
    RX_WAIT_HIGH
  } rx_state_e;

endpackage

// File: rtl/servo_uart_cmd_rx_byte.sv
// 8N1 UART byte receiver: 2-FF synchronizer, bit FSM and baud counter.
// Emits a one-cycle byte strobe, or a framing-error strobe on a low stop bit.
module uart_rx_byte #(
  parameter int CLKS_PER_BIT = mg995_parameters::CLKS_PER_BIT
) (
  input  logic       Clk_i,
  input  logic       Reset_i,
  input  logic       i_rx,
  output logic [7:0] o_byte,
  output logic       o_byte_valid,
  output logic       o_frame_err
);
  import mg995_parameters::*;

  localparam int HALF_BIT = CLKS_PER_BIT / 2;
  localparam int CNT_W    = $clog2(CLKS_PER_BIT);

  logic             r_sync1, r_sync2;
  rx_state_e        r_state, w_next_state;
  logic [CNT_W-1:0] r_cnt;
  logic [2:0]       r_bit_idx;
  logic [7:0]       r_shift;
  logic             r_byte_valid, r_frame_err;

  logic w_rx, w_cnt_zero;
  logic w_load_half, w_load_full, w_shift, w_byte_done, w_frame_err;

  assign w_rx       = r_sync2;
  assign w_cnt_zero = (r_cnt == '0);

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge Clk_i or negedge Reset_i) begin
    if (!Reset_i) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
      r_state <= RX_IDLE;
    end else begin
      r_sync1 <= i_rx;
      r_sync2 <= r_sync1;
      r_state <= w_next_state;
    end
  end

  // NOTE: every output of this block gets a default first, so no path infers a latch.
  always_comb begin
    w_next_state = r_state;
    w_load_half  = 1'b0;
    w_load_full  = 1'b0;
    w_shift      = 1'b0;
    w_byte_done  = 1'b0;
    w_frame_err  = 1'b0;
    unique case (r_state)
      RX_IDLE: if (!w_rx) begin
        w_next_state = RX_START;
        w_load_half  = 1'b1;
      end
      RX_START: if (w_cnt_zero) begin
        if (!w_rx) begin
          w_next_state = RX_DATA;
          w_load_full  = 1'b1;
        end else begin
          w_next_state = RX_IDLE;
        end
      end
      RX_DATA: if (w_cnt_zero) begin
        w_shift     = 1'b1;
        w_load_full = 1'b1;
        if (r_bit_idx == 3'd7) w_next_state = RX_STOP;
      end
      RX_STOP: if (w_cnt_zero) begin
        if (w_rx) begin
          w_byte_done  = 1'b1;
          w_next_state = RX_IDLE;
        end else begin
          w_frame_err  = 1'b1;
          w_next_state = RX_WAIT_HIGH;
        end
      end
      RX_WAIT_HIGH: if (w_rx) w_next_state = RX_IDLE;
      default: w_next_state = RX_IDLE;
    endcase
  end

  always_ff @(posedge Clk_i or negedge Reset_i) begin
    if (!Reset_i) begin
      r_cnt        <= '0;
      r_bit_idx    <= '0;
      r_shift      <= '0;
      r_byte_valid <= 1'b0;
      r_frame_err  <= 1'b0;
    end else begin
      if (w_load_half)      r_cnt <= CNT_W'(HALF_BIT - 1);
      else if (w_load_full) r_cnt <= CNT_W'(CLKS_PER_BIT - 1);
      else if (!w_cnt_zero) r_cnt <= r_cnt - 1'b1;

      if (w_load_half)  r_bit_idx <= '0;
      else if (w_shift) r_bit_idx <= r_bit_idx + 1'b1;

      if (w_shift) r_shift <= {w_rx, r_shift[7:1]};

      r_byte_valid <= w_byte_done;
      r_frame_err  <= w_frame_err;
    end
  end

  assign o_byte       = r_shift;
  assign o_byte_valid = r_byte_valid;
  assign o_frame_err  = r_frame_err;

endmodule

// File: rtl/servo_uart_cmd_rx.sv
// ASCII angle command parser: "<0|90|180><CR|LF>" becomes a PWM compare value;
// malformed or out-of-set commands and framing errors pulse Error_o.
module servo_uart_cmd_rx #(
  parameter int CLKS_PER_BIT = mg995_parameters::CLKS_PER_BIT,
  parameter int DATA_LENGTH  = mg995_parameters::DATA_LENGTH,
  parameter int ANGLE_0_P    = mg995_parameters::ANGLE_0_P,
  parameter int ANGLE_90_P   = mg995_parameters::ANGLE_90_P,
  parameter int ANGLE_180_P  = mg995_parameters::ANGLE_180_P
) (
  input  logic                   Clk_i,
  input  logic                   Reset_i,
  input  logic                   Rx_i,
  output logic [DATA_LENGTH-1:0] Data_o,
  output logic                   Valid_o,
  output logic                   Error_o
);
  import mg995_parameters::*;

  logic [7:0] w_byte;
  logic       w_byte_valid, w_frame_err;

  uart_rx_byte #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
    .Clk_i       (Clk_i),
    .Reset_i     (Reset_i),
    .i_rx        (Rx_i),
    .o_byte      (w_byte),
    .o_byte_valid(w_byte_valid),
    .o_frame_err (w_frame_err)
  );

  logic [7:0]             r_acc;
  logic [1:0]             r_nd;
  logic                   r_bad;
  logic [DATA_LENGTH-1:0] r_data;
  logic                   r_valid, r_error;

  logic                   w_is_digit, w_is_term, w_hit, w_cmd_ok, w_cmd_err;
  logic [9:0]             w_acc_next;
  logic [DATA_LENGTH-1:0] w_angle_val;

  assign w_is_digit = (w_byte >= ASCII_0) && (w_byte <= ASCII_9);
  assign w_is_term  = (w_byte == ASCII_CR) || (w_byte == ASCII_LF);
  // At most two digits precede an accumulate, so the 10-bit sum never exceeds 999.
  assign w_acc_next = {2'b00, r_acc} * 10'd10 + {6'd0, w_byte[3:0]};

  always_comb begin
    w_hit       = 1'b1;
    w_angle_val = DATA_LENGTH'(ANGLE_90_P);
    unique case (r_acc)
      8'd0:    w_angle_val = DATA_LENGTH'(ANGLE_0_P);
      8'd90:   w_angle_val = DATA_LENGTH'(ANGLE_90_P);
      8'd180:  w_angle_val = DATA_LENGTH'(ANGLE_180_P);
      default: w_hit = 1'b0;
    endcase
  end

  // Empty lines (e.g. the LF of CRLF) are neither accepted nor rejected.
  assign w_cmd_ok  = w_byte_valid && w_is_term && !r_bad && (r_nd != 2'd0) && w_hit;
  assign w_cmd_err = w_byte_valid && w_is_term && (r_bad || ((r_nd != 2'd0) && !w_hit));

  always_ff @(posedge Clk_i or negedge Reset_i) begin
    if (!Reset_i) begin
      r_acc <= '0;
      r_nd  <= '0;
      r_bad <= 1'b0;
    end else if (w_byte_valid) begin
      if (w_is_term) begin
        r_acc <= '0;
        r_nd  <= '0;
        r_bad <= 1'b0;
      end else if (w_is_digit && !r_bad && (r_nd != 2'd3)) begin
        // Saturate so a three-digit value above 255 cannot alias onto a valid angle.
        r_acc <= (w_acc_next > 10'd255) ? 8'd255 : w_acc_next[7:0];
        r_nd  <= r_nd + 1'b1;
      end else begin
        r_bad <= 1'b1;
      end
    end
  end

  always_ff @(posedge Clk_i or negedge Reset_i) begin
    if (!Reset_i) begin
      r_data  <= DATA_LENGTH'(ANGLE_90_P);
      r_valid <= 1'b0;
      r_error <= 1'b0;
    end else begin
      r_valid <= w_cmd_ok;
      r_error <= w_cmd_err || w_frame_err;
      if (w_cmd_ok) r_data <= w_angle_val;
    end
  end

  assign Data_o  = r_data;
  assign Valid_o = r_valid;
  assign Error_o = r_error;

endmodule

// File: tb/tb_servo_uart_cmd_rx.sv
// Self-checking bench: drives UART frames, predicts each command's outcome
// from its text, and checks every output pulse against that prediction.
module tb_servo_uart_cmd_rx;

  localparam int CPB  = 16;
  localparam int HALF = CPB / 2;

  logic        Clk_i = 1'b0;
  logic        Reset_i;
  logic        Rx_i;
  logic [16:0] Data_o;
  logic        Valid_o, Error_o;

  servo_uart_cmd_rx #(.CLKS_PER_BIT(CPB)) dut (
    .Clk_i  (Clk_i),
    .Reset_i(Reset_i),
    .Rx_i   (Rx_i),
    .Data_o (Data_o),
    .Valid_o(Valid_o),
    .Error_o(Error_o)
  );

  always #5 Clk_i = ~Clk_i;

  typedef struct {
    bit is_valid;
    int data;
  } exp_t;

  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;
  int   last_start;
  int   last_pulse_cyc = -1;
  int   model_data = 74999;
  exp_t exp_q[$];
  byte  line_q[$];
  exp_t e_cur;

  always @(posedge Clk_i) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Compare process: every output pulse must match the next predicted outcome.
  always @(negedge Clk_i) begin
    if (Reset_i === 1'b1 && (Valid_o !== 1'b0 || Error_o !== 1'b0)) begin
      last_pulse_cyc = cyc;
      check("valid_error_exclusive", 32'(Valid_o & Error_o), 0);
      if (exp_q.size() == 0) begin
        check("unexpected_pulse", {30'd0, Valid_o, Error_o}, 0);
      end else begin
        e_cur = exp_q.pop_front();
        check("pulse_valid", 32'(Valid_o), 32'(e_cur.is_valid));
        check("pulse_error", 32'(Error_o), 32'(!e_cur.is_valid));
        if (e_cur.is_valid) model_data = e_cur.data;
        check("data_on_pulse", 32'(Data_o), model_data);
      end
    end
  end

  // Outcome of one command line, judged from its text alone.
  task automatic judge_line();
    bit   bad;
    int   val;
    exp_t e;
    if (line_q.size() == 0) return;
    bad = (line_q.size() > 3);
    val = 0;
    foreach (line_q[i]) begin
      if (line_q[i] < "0" || line_q[i] > "9") bad = 1;
      else val = val * 10 + (line_q[i] - "0");
    end
    e.is_valid = 0;
    e.data     = 0;
    if (!bad && val == 0)   begin e.is_valid = 1; e.data = 24999;  end
    if (!bad && val == 90)  begin e.is_valid = 1; e.data = 74999;  end
    if (!bad && val == 180) begin e.is_valid = 1; e.data = 124999; end
    exp_q.push_back(e);
    line_q.delete();
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_lvl);
    @(posedge Clk_i); #1;
    Rx_i = 1'b0;
    last_start = cyc;
    repeat (CPB) @(posedge Clk_i);
    for (int i = 0; i < 8; i++) begin
      #1 Rx_i = b[i];
      repeat (CPB) @(posedge Clk_i);
    end
    #1 Rx_i = stop_lvl;
    repeat (CPB) @(posedge Clk_i);
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) begin
      if (s[i] == 8'h0D || s[i] == 8'h0A) judge_line();
      else line_q.push_back(s[i]);
      send_byte(s[i], 1'b1);
    end
  endtask

  task automatic wait_quiet();
    for (int i = 0; i < 4 * CPB && exp_q.size() != 0; i++) @(posedge Clk_i);
    check("pending_expectations", exp_q.size(), 0);
    exp_q.delete();
    @(negedge Clk_i);
  endtask

  initial begin
    repeat (150000) @(posedge Clk_i);
    $display("FAIL watchdog: simulation exceeded cycle budget");
    $fatal(1, "watchdog");
  end

  initial begin
    string cmd;
    int    kind, n;
    Reset_i = 1'b0;
    Rx_i    = 1'b1;
    repeat (3) @(posedge Clk_i);
    @(negedge Clk_i);
    check("reset_data", 32'(Data_o), 74999);
    check("reset_valid", 32'(Valid_o), 0);
    check("reset_error", 32'(Error_o), 0);
    @(posedge Clk_i); #1 Reset_i = 1'b1;
    repeat (4) @(posedge Clk_i);

    // "90\r": fixed latency from the CR start bit to the Valid_o pulse.
    last_pulse_cyc = -1;
    send_str("90\r");
    wait_quiet();
    check("latency_90", last_pulse_cyc - last_start, 4 + HALF + 9 * CPB);
    check("data_90", 32'(Data_o), 74999);

    send_str("180\r\n");
    wait_quiet();
    check("data_180", 32'(Data_o), 124999);
    send_str("0\n");
    wait_quiet();
    check("data_0", 32'(Data_o), 24999);

    send_str("45\r");   wait_quiet(); check("hold_45", 32'(Data_o), 24999);
    send_str("1800\r"); wait_quiet(); check("hold_1800", 32'(Data_o), 24999);
    send_str("9a\r");   wait_quiet(); check("hold_9a", 32'(Data_o), 24999);

    // Short low glitch: no strobe, no error, receiver still usable.
    @(posedge Clk_i); #1 Rx_i = 1'b0;
    repeat (HALF - 3) @(posedge Clk_i);
    #1 Rx_i = 1'b1;
    repeat (3 * CPB) @(posedge Clk_i);
    send_str("90\r");
    wait_quiet();
    check("after_glitch", 32'(Data_o), 74999);

    // Framing error then a held-low break: one error only.
    exp_q.push_back('{is_valid: 1'b0, data: 0});
    send_byte(8'h39, 1'b0);
    repeat (3 * CPB) @(posedge Clk_i);
    #1 Rx_i = 1'b1;
    repeat (CPB) @(posedge Clk_i);
    wait_quiet();
    send_str("0\r");
    wait_quiet();
    check("after_break", 32'(Data_o), 24999);

    // Reset during data bit 4 of '9' discards the partial line.
    send_str("1");
    @(posedge Clk_i); #1 Rx_i = 1'b0;
    repeat (CPB) @(posedge Clk_i);
    for (int i = 0; i < 5; i++) begin
      #1 Rx_i = 8'h39 >> i;
      repeat (CPB) @(posedge Clk_i);
    end
    repeat (HALF) @(posedge Clk_i);
    #1 Reset_i = 1'b0;
    Rx_i = 1'b1;
    line_q.delete();
    exp_q.delete();
    model_data = 74999;
    repeat (2) @(posedge Clk_i);
    @(negedge Clk_i);
    check("midreset_data", 32'(Data_o), 74999);
    check("midreset_valid", 32'(Valid_o), 0);
    check("midreset_error", 32'(Error_o), 0);
    @(posedge Clk_i); #1 Reset_i = 1'b1;
    repeat (CPB) @(posedge Clk_i);
    send_str("180\r");
    wait_quiet();
    check("after_reset_180", 32'(Data_o), 124999);

    // Randomized command mix.
    for (int k = 0; k < 28; k++) begin
      kind = $urandom_range(0, 5);
      case (kind)
        0: begin
          n = $urandom_range(0, 2) * 90;
          cmd = $sformatf("%0d", n);
        end
        1: cmd = $sformatf("%0d", $urandom_range(0, 999));
        2: cmd = $sformatf("%0d", $urandom_range(1000, 9999));
        3: begin
          cmd = $sformatf("%0d", $urandom_range(0, 99));
          cmd = {cmd, string'(byte'($urandom_range(8'h20, 8'h7E)))};
        end
        4: cmd = "";
        default: cmd = $sformatf("0%0d", $urandom_range(0, 2) * 90);
      endcase
      case ($urandom_range(0, 2))
        0:       cmd = {cmd, "\r"};
        1:       cmd = {cmd, "\n"};
        default: cmd = {cmd, "\r\n"};
      endcase
      repeat ($urandom_range(0, 5)) @(posedge Clk_i);
      send_str(cmd);
      wait_quiet();
      check("random_data_hold", 32'(Data_o), model_data);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
